// File: rtl/fpu_issue_ctrl.sv
// Issue/sequencing stage in front of the Q15 fixed-point FPU.
// Accepts one request at a time, drives the FPU opcode/operands, sequences the
// multi-cycle divide around fpu_busy and returns one tagged response per request.
module fpu_issue_ctrl #(
   parameter int unsigned TAG_W       = 4,
   parameter int unsigned DIV_TIMEOUT = 256
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [63:0]      req_a,
   input  logic [63:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic [3:0]       fpu_op,
   output logic [63:0]      a_data,
   output logic [63:0]      b_data,
   input  logic             fpu_busy,
   input  logic [63:0]      fpu_res,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [63:0]      rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [1:0]       rsp_err
);

   localparam int unsigned CNT_W  = $clog2(DIV_TIMEOUT + 1);
   localparam logic [3:0]  OP_DIV = 4'b0011;
   localparam logic [3:0]  OP_NOP = 4'b0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RESP_ERR,
      ST_DIV_DRAIN,
      ST_DIV_LAUNCH,
      ST_DIV_WAIT
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         op_q, op_d;
   logic [63:0]        a_q, a_d;
   logic [63:0]        b_q, b_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic               drain_q, drain_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [63:0]        rsp_data_q, rsp_data_d;
   logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
   logic [1:0]         rsp_err_q, rsp_err_d;

   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
         4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101: op_legal = 1'b1;
         default:                                       op_legal = 1'b0;
      endcase
   endfunction

   assign req_ready = (state_q == ST_IDLE) && !rsp_valid_q;
   assign a_data    = a_q;
   assign b_data    = b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_tag   = rsp_tag_q;
   assign rsp_err   = rsp_err_q;

   // Register all state; reset aborts any operation without a response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         tag_q       <= '0;
         drain_q     <= 1'b0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_tag_q   <= '0;
         rsp_err_q   <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         tag_q       <= tag_d;
         drain_q     <= drain_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_tag_q   <= rsp_tag_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Next-state, FPU drive and response generation.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      tag_d       = tag_q;
      drain_d     = drain_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_tag_d   = rsp_tag_q;
      rsp_err_d   = rsp_err_q;
      fpu_op      = OP_NOP;

      // The divide-completion edge sets drain below and overrides this clear,
      // since the FPU relaunches on that very edge.
      if (!fpu_busy) begin
         drain_d = 1'b0;
      end
      if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               op_d  = req_op;
               a_d   = req_a;
               b_d   = req_b;
               tag_d = req_tag;
               if (!op_legal(req_op)) begin
                  state_d = ST_RESP_ERR;
               end else if (req_op == OP_DIV) begin
                  state_d = drain_q ? ST_DIV_DRAIN : ST_DIV_LAUNCH;
               end else begin
                  state_d = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            fpu_op      = op_q;
            rsp_data_d  = fpu_res;
            rsp_err_d   = 2'd0;
            rsp_tag_d   = tag_q;
            rsp_valid_d = 1'b1;
            state_d     = ST_IDLE;
         end
         ST_RESP_ERR: begin
            rsp_data_d  = '0;
            rsp_err_d   = 2'd1;
            rsp_tag_d   = tag_q;
            rsp_valid_d = 1'b1;
            state_d     = ST_IDLE;
         end
         ST_DIV_DRAIN: begin
            if (!drain_q) begin
               state_d = ST_DIV_LAUNCH;
            end
         end
         ST_DIV_LAUNCH: begin
            fpu_op  = OP_DIV;
            cnt_d   = '0;
            state_d = ST_DIV_WAIT;
         end
         ST_DIV_WAIT: begin
            fpu_op = OP_DIV;
            if (!fpu_busy) begin
               rsp_data_d  = fpu_res;
               rsp_err_d   = 2'd0;
               rsp_tag_d   = tag_q;
               rsp_valid_d = 1'b1;
               drain_d     = 1'b1;
               state_d     = ST_IDLE;
            end else if ((cnt_q + CNT_W'(1)) == CNT_W'(DIV_TIMEOUT)) begin
               rsp_data_d  = '0;
               rsp_err_d   = 2'd2;
               rsp_tag_d   = tag_q;
               rsp_valid_d = 1'b1;
               drain_d     = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule
